// File: rtl/dft8_pass_scheduler_pkg.sv
// Shared widths, FSM encodings and the complex result word for the 8-point DFT pass scheduler.
package dft8_pass_scheduler_pkg;

   localparam int unsigned SAMPLE_W = 8;
   localparam int unsigned N_POINTS = 8;

   localparam logic [2:0] ST_LOAD    = 3'd0;
   localparam logic [2:0] ST_OP_EVEN = 3'd1;
   localparam logic [2:0] ST_OP_ODD  = 3'd2;
   localparam logic [2:0] ST_CAP_ODD = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;

   typedef struct packed {
      logic [SAMPLE_W-1:0] re;
      logic [SAMPLE_W-1:0] im;
   } cplx_t;

endpackage

// File: rtl/dft8_pass_scheduler_if.sv
// Sample-in / spectrum-out stream bundle; master is the environment, slave is the scheduler.
interface dft8_pass_scheduler_if;
   import dft8_pass_scheduler_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [SAMPLE_W-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [SAMPLE_W-1:0] out_re;
   logic [SAMPLE_W-1:0] out_im;
   logic [2:0]          out_idx;
   logic                out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_re, out_im, out_idx, out_last
   );

endinterface

// File: rtl/butterfly_point_4.sv
// Combinational 4-point DFT on real inputs; all results wrap mod 256.
module butterfly_point_4 (
   input  logic [7:0] x0,
   input  logic [7:0] x2,
   input  logic [7:0] x4,
   input  logic [7:0] x6,
   output logic [7:0] b0_re,
   output logic [7:0] b0_im,
   output logic [7:0] b1_re,
   output logic [7:0] b1_im,
   output logic [7:0] b2_re,
   output logic [7:0] b2_im,
   output logic [7:0] b3_re,
   output logic [7:0] b3_im
);

   always_comb begin
      b0_re = x0 + x2 + x4 + x6;
      b0_im = 8'h00;
      b1_re = x0 - x4;
      b1_im = x6 - x2;
      b2_re = (x0 + x4) - (x2 + x6);
      b2_im = 8'h00;
      b3_re = x0 - x4;
      b3_im = x2 - x6;
   end

endmodule

// File: rtl/dft8_pass_scheduler.sv
// Buffers an 8-sample frame, runs one 4-point butterfly twice (even, then odd samples),
// and streams the two captured spectra out as 8 complex words.
module dft8_pass_scheduler
   import dft8_pass_scheduler_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   dft8_pass_scheduler_if.slave  bus,
   output logic                  busy
);

   logic [2:0]          state;
   logic [2:0]          count;
   logic [2:0]          drain_idx;
   logic [SAMPLE_W-1:0] sbuf [N_POINTS];
   logic [SAMPLE_W-1:0] op   [4];
   cplx_t               res  [N_POINTS];
   logic [SAMPLE_W-1:0] bf_re [4];
   logic [SAMPLE_W-1:0] bf_im [4];
   logic                in_fire;
   logic                out_fire;

   assign in_fire  = (state == ST_LOAD) && bus.in_valid;
   assign out_fire = (state == ST_DRAIN) && bus.out_ready;

   butterfly_point_4 u_bf (
      .x0    (op[0]),
      .x2    (op[1]),
      .x4    (op[2]),
      .x6    (op[3]),
      .b0_re (bf_re[0]),
      .b0_im (bf_im[0]),
      .b1_re (bf_re[1]),
      .b1_im (bf_im[1]),
      .b2_re (bf_re[2]),
      .b2_im (bf_im[2]),
      .b3_re (bf_re[3]),
      .b3_im (bf_im[3])
   );

   // Sample buffer and operands carry no reset; they are always rewritten before use.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         sbuf[count] <= bus.in_data;
      end
      if (state == ST_OP_EVEN) begin
         op[0] <= sbuf[0];
         op[1] <= sbuf[2];
         op[2] <= sbuf[4];
         op[3] <= sbuf[6];
      end else if (state == ST_OP_ODD) begin
         op[0] <= sbuf[1];
         op[1] <= sbuf[3];
         op[2] <= sbuf[5];
         op[3] <= sbuf[7];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_LOAD;
         count     <= 3'd0;
         drain_idx <= 3'd0;
         for (int i = 0; i < N_POINTS; i++) begin
            res[i] <= '0;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_fire) begin
                  count <= count + 3'd1;
                  if (count == 3'd7) begin
                     state <= ST_OP_EVEN;
                  end
               end
            end
            ST_OP_EVEN: state <= ST_OP_ODD;
            ST_OP_ODD: begin
               for (int k = 0; k < 4; k++) begin
                  res[k] <= '{re: bf_re[k], im: bf_im[k]};
               end
               state <= ST_CAP_ODD;
            end
            ST_CAP_ODD: begin
               for (int k = 0; k < 4; k++) begin
                  res[k + 4] <= '{re: bf_re[k], im: bf_im[k]};
               end
               state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (out_fire) begin
                  if (drain_idx == 3'd7) begin
                     state     <= ST_LOAD;
                     drain_idx <= 3'd0;
                     count     <= 3'd0;
                  end else begin
                     drain_idx <= drain_idx + 3'd1;
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   assign bus.in_ready  = (state == ST_LOAD);
   assign bus.out_valid = (state == ST_DRAIN);
   assign bus.out_re    = res[drain_idx].re;
   assign bus.out_im    = res[drain_idx].im;
   assign bus.out_idx   = drain_idx;
   assign bus.out_last  = (state == ST_DRAIN) && (drain_idx == 3'd7);
   assign busy          = (state != ST_LOAD);

endmodule
